mxrv_csr_unit: RTL and testbench
================================

// Module: mxrv_csr_unit
// PURPOSE
//  Machine-mode CSR unit for the mxrv core; successor to the simple CSR register file.
//  - Parametrised in XLEN.
//  - CSRRW/CSRRS/CSRRC operations and illegal-access detection.
//  - Free-running 64-bit mcycle/minstret counters.
//  - Trap entry and mret sequencing.
//  - Sits beside the execute stage. Feeds mtvec/mepc to the PC logic for trap and mret redirects.
// PARAMETERS
//  XLEN         32            data width (32 only; counters split into low/high halves)
//  HART_ID      0             value returned by mhartid (0xF14)
//  MISA_VAL     32'h40000100  value returned by misa (0x301), RV32I
//  MTVEC_RESET  32'h00000000  reset value of mtvec
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst           in   1     synchronous reset, active-high
//  csr_addr_i    in   12    CSR address
//  csr_op_i      in   2     00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
//  csr_wdata_i   in   XLEN  operand for RW/RS/RC
//  csr_rdata_o   out  XLEN  current (pre-write) value of addressed CSR, combinational
//  csr_illegal_o out  1     access illegal this cycle, combinational
//  instret_i     in   1     one instruction retired this cycle
//  trap_i        in   1     take trap this cycle
//  trap_cause_i  in   XLEN  mcause value for trap
//  trap_pc_i     in   XLEN  PC of trapping instruction
//  mret_i        in   1     execute mret this cycle
//  mtvec_o       out  XLEN  trap vector base ({mtvec[XLEN-1:2],2'b00})
//  mepc_o        out  XLEN  return address
//  mie_o         out  1     mstatus.MIE
// BEHAVIOUR
//  Implemented CSRs: mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341,
//    mcause 342, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82, mhartid F14.
//  Reset values:
//    - All registers 0, except mtvec = MTVEC_RESET.
//    - Outputs follow: mtvec_o = MTVEC_RESET, mepc_o = 0, mie_o = 0.
//  Reads:
//    - Zero latency, pre-write value.
//    - Unimplemented address reads 0.
//    - mip always reads 0.
//  Read-only field values:
//    - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; other bits read 0.
//    - mtvec[1:0] and mepc[1:0] are forced 0 (direct mode only).
//  Write value (committed on next rising edge):
//    - RW: wdata.
//    - RS: old | wdata.
//    - RC: old & ~wdata.
//    - RS/RC with wdata==0 perform no write.
//  csr_illegal_o = 1 when csr_op_i!=00 AND either:
//    - the address is unimplemented, or
//    - addr[11:10]==2'b11 (read-only) and a write would occur (RW always; RS/RC when wdata!=0).
//    Illegal access: no state change. csr_op_i==00 never flags.
//  Counters:
//    - mcycle (64b) increments every cycle after reset.
//    - minstret (64b) increments when instret_i=1.
//    - Both wrap 2^64-1 -> 0.
//  SW write to a counter half in the same cycle as an increment:
//    - Low half write: low = new value, high unchanged (no carry).
//    - High half write: high = new value, low = low+1, carry discarded.
//  Trap entry (trap_i=1):
//    - mepc <= trap_pc_i & ~3; mcause <= trap_cause_i.
//    - MPIE <= MIE; MIE <= 0.
//  mret_i=1: MIE <= MPIE, MPIE <= 1.
//  Priority: trap_i > mret_i > CSR write.
//    - A lower-priority event in the same cycle is dropped.
//    - Counters still advance.
//  rst asserted mid-operation:
//    - All state returns to reset values on that edge.
//    - Pending write/trap is discarded.
// TESTING
//  1. Reset, op=00 addr=301 -> rdata=40000100, illegal=0; addr=F14 -> 0; mcycle counts 0,1,2...
//  2. RW 305<=0x80000003 -> next cycle rdata=0x80000000, mtvec_o=0x80000000;
//     then RS 340 0x0F, RC 340 0x05 -> mscratch=0x0A.
//  3. RW F14 or addr 7C0 -> illegal=1, no state change;
//     RS F14 wdata=0 -> illegal=0; RW B00<=0xFFFFFFFF, next edge low wraps, mcycleh+1.
//  4. mstatus.MIE=1, trap_i cause=0xB pc=0x1006 with simultaneous RW 340
//     -> mepc=0x1004, mcause=0xB, MIE=0, MPIE=1, mscratch unchanged.
//  5. mret_i after case 4 -> MIE=1, MPIE=1; trap_i and mret_i together -> trap wins.
//  6. Pulse instret_i 5 cycles, rst mid-run -> minstret=5 before rst, 0 after; mcycle=0.

Source files
------------

// File: rtl/mxrv_csr_if.sv
// CSR access, trap/mret control and redirect outputs between the mxrv
// execute stage (master) and the machine-mode CSR unit (slave).
interface mxrv_csr_if #(
  parameter int unsigned XLEN = 32
);
  logic [11:0]     csr_addr_i;
  logic [1:0]      csr_op_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;
  logic            instret_i;
  logic            trap_i;
  logic [XLEN-1:0] trap_cause_i;
  logic [XLEN-1:0] trap_pc_i;
  logic            mret_i;
  logic [XLEN-1:0] mtvec_o;
  logic [XLEN-1:0] mepc_o;
  logic            mie_o;

  modport master (
    output csr_addr_i, csr_op_i, csr_wdata_i, instret_i,
           trap_i, trap_cause_i, trap_pc_i, mret_i,
    input  csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_o
  );

  modport slave (
    input  csr_addr_i, csr_op_i, csr_wdata_i, instret_i,
           trap_i, trap_cause_i, trap_pc_i, mret_i,
    output csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_o
  );
endinterface

// File: rtl/mxrv_csr_unit.sv
// Machine-mode CSR unit for the mxrv core: CSRRW/RS/RC access with illegal
// detection, 64-bit mcycle/minstret counters, trap entry and mret sequencing.
// Counter halves are 32 bits wide, so XLEN is expected to be 32.
module mxrv_csr_unit #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  HART_ID     = '0,
  parameter logic [XLEN-1:0]  MISA_VAL    = 32'h40000100,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
  input  logic         clk,
  input  logic         rst,
  mxrv_csr_if.slave    bus
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Direct-mode vector and return address are always word aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  csr_op_e         op;
  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]     mcycle_q, minstret_q;
  logic [XLEN-1:0] mstatus_rd, rdata, wval;
  logic            implemented, write_req, illegal, csr_we;

  assign op = csr_op_e'(bus.csr_op_i);

  // Assemble the architectural mstatus view: MPP hardwired to machine mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mstatus_mpie;
    mstatus_rd[3]     = mstatus_mie;
  end

  // Zero-latency read mux returning the pre-write value of the addressed CSR.
  always_comb begin
    rdata       = '0;
    implemented = 1'b1;
    case (bus.csr_addr_i)
      CSR_MSTATUS:   rdata = mstatus_rd;
      CSR_MISA:      rdata = MISA_VAL;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MIP:       rdata = '0;
      CSR_MCYCLE:    rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   rdata = mcycle_q[63:32];
      CSR_MINSTRET:  rdata = minstret_q[31:0];
      CSR_MINSTRETH: rdata = minstret_q[63:32];
      CSR_MHARTID:   rdata = HART_ID;
      default:       implemented = 1'b0;
    endcase
  end

  // Compute the write value and decide whether a legal write commits this cycle.
  always_comb begin
    case (op)
      OP_RW:   wval = bus.csr_wdata_i;
      OP_RS:   wval = rdata | bus.csr_wdata_i;
      OP_RC:   wval = rdata & ~bus.csr_wdata_i;
      default: wval = rdata;
    endcase
    // RS/RC with a zero mask are pure reads and never count as writes.
    write_req = (op == OP_RW) || ((op != OP_NONE) && (|bus.csr_wdata_i));
    illegal   = (op != OP_NONE) &&
                (!implemented || ((bus.csr_addr_i[11:10] == 2'b11) && write_req));
    csr_we    = write_req && !illegal && !bus.trap_i && !bus.mret_i;
  end

  // Trap entry, mret and software writes to the non-counter CSRs, in that priority.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high; every register, including the counters, has a reset value.
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else if (bus.trap_i) begin
      // NOTE: non-blocking assignments let MPIE capture the old MIE in the same edge.
      mepc_q       <= bus.trap_pc_i & ALIGN_MASK;
      mcause_q     <= bus.trap_cause_i;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (bus.mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie  <= wval[3];
          mstatus_mpie <= wval[7];
        end
        CSR_MIE:      mie_q      <= wval;
        CSR_MTVEC:    mtvec_q    <= wval & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= wval & ALIGN_MASK;
        CSR_MCAUSE:   mcause_q   <= wval;
        default: ;
      endcase
    end
  end

  // Free-running counters; a software half-write replaces that half, the other half follows the increment rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && bus.csr_addr_i == CSR_MCYCLE)
        mcycle_q[31:0] <= wval;
      else if (csr_we && bus.csr_addr_i == CSR_MCYCLEH)
        mcycle_q <= {wval, mcycle_q[31:0] + 32'd1};
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (csr_we && bus.csr_addr_i == CSR_MINSTRET)
        minstret_q[31:0] <= wval;
      else if (csr_we && bus.csr_addr_i == CSR_MINSTRETH)
        minstret_q <= {wval, minstret_q[31:0] + {31'd0, bus.instret_i}};
      else if (bus.instret_i)
        minstret_q <= minstret_q + 64'd1;
    end
  end

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = illegal;
  assign bus.mtvec_o       = mtvec_q;
  assign bus.mepc_o        = mepc_q;
  assign bus.mie_o         = mstatus_mie;

endmodule

// File: tb/tb_mxrv_csr_unit.sv
// Self-checking bench for mxrv_csr_unit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_mxrv_csr_unit;
  localparam int XLEN = 32;

  logic clk;
  logic rst;
  mxrv_csr_if #(.XLEN(XLEN)) bus ();

  mxrv_csr_unit #(
    .XLEN(XLEN), .HART_ID(32'h0), .MISA_VAL(32'h40000100), .MTVEC_RESET(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        instret;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] pc;
    logic        mret;
  } stim_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: architectural values of every CSR.
  bit          m_valid = 1'b0;
  logic        m_mie, m_mpie;
  logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {implemented, value} for an address from the model's view.
  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
      12'h301: return {1'b1, 32'h40000100};
      12'h304: return {1'b1, m_mier};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h344: return {1'b1, 32'h0};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB02: return {1'b1, m_ins[31:0]};
      12'hB82: return {1'b1, m_ins[63:32]};
      12'hF14: return {1'b1, 32'h0};
      default: return 33'h0;
    endcase
  endfunction

  function automatic bit model_wants_write();
    return (bus.csr_op_i == 2'd1) || (bus.csr_op_i != 2'd0 && bus.csr_wdata_i != 32'h0);
  endfunction

  function automatic bit model_illegal();
    logic [32:0] r;
    r = model_read(bus.csr_addr_i);
    return (bus.csr_op_i != 2'd0) &&
           (!r[32] || (bus.csr_addr_i[11:10] == 2'b11 && model_wants_write()));
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    logic [31:0] old, nv;
    logic [63:0] cyc_next, ins_next;
    bit wr;
    if (rst) begin
      m_valid = 1'b1;
      m_mie = 1'b0; m_mpie = 1'b0;
      m_mier = '0; m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
      m_cyc = '0; m_ins = '0;
      return;
    end
    old = model_read(bus.csr_addr_i) >> 0;
    case (bus.csr_op_i)
      2'd1:    nv = bus.csr_wdata_i;
      2'd2:    nv = old | bus.csr_wdata_i;
      2'd3:    nv = old & ~bus.csr_wdata_i;
      default: nv = old;
    endcase
    wr = model_wants_write() && !model_illegal() && !bus.trap_i && !bus.mret_i;
    cyc_next = m_cyc + 64'd1;
    ins_next = m_ins + (bus.instret_i ? 64'd1 : 64'd0);
    if (bus.trap_i) begin
      m_mepc = bus.trap_pc_i & ~32'd3;
      m_mcause = bus.trap_cause_i;
      m_mpie = m_mie;
      m_mie = 1'b0;
    end else if (bus.mret_i) begin
      m_mie = m_mpie;
      m_mpie = 1'b1;
    end else if (wr) begin
      case (bus.csr_addr_i)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mier = nv;
        12'h305: m_mtvec = nv & ~32'd3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'd3;
        12'h342: m_mcause = nv;
        12'hB00: cyc_next = {m_cyc[63:32], nv};
        12'hB80: cyc_next = {nv, cyc_next[31:0]};
        12'hB02: ins_next = {m_ins[63:32], nv};
        12'hB82: ins_next = {nv, ins_next[31:0]};
        default: ;
      endcase
    end
    m_cyc = cyc_next;
    m_ins = ins_next;
  endtask

  // Compare every DUT output against the model for the currently applied inputs.
  task automatic compare_outputs();
    logic [32:0] r;
    r = model_read(bus.csr_addr_i);
    check("rdata", bus.csr_rdata_o, r[31:0]);
    check("illegal", {31'd0, bus.csr_illegal_o}, {31'd0, model_illegal()});
    check("mtvec_o", bus.mtvec_o, m_mtvec);
    check("mepc_o", bus.mepc_o, m_mepc);
    check("mie_o", {31'd0, bus.mie_o}, {31'd0, m_mie});
  endtask

  // One cycle: commit the previous inputs to the model, drive new ones, compare.
  task automatic step(input stim_t s);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst              = s.rst;
    bus.csr_addr_i   = s.addr;
    bus.csr_op_i     = s.op;
    bus.csr_wdata_i  = s.wdata;
    bus.instret_i    = s.instret;
    bus.trap_i       = s.trap;
    bus.trap_cause_i = s.cause;
    bus.trap_pc_i    = s.pc;
    bus.mret_i       = s.mret;
    #1;
    if (m_valid) compare_outputs();
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    stim_t s;
    s = '0;
    s.addr = a; s.op = op; s.wdata = wd;
    step(s);
  endtask

  localparam logic [11:0] ADDRS [15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
    12'h341, 12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h123};

  initial begin
    stim_t s;
    rst = 1'b1;
    bus.csr_addr_i = '0; bus.csr_op_i = '0; bus.csr_wdata_i = '0; bus.instret_i = 1'b0;
    bus.trap_i = 1'b0; bus.trap_cause_i = '0; bus.trap_pc_i = '0; bus.mret_i = 1'b0;

    // Reset state and counter start.
    s = '0; s.rst = 1'b1;
    step(s);
    step(s);
    check("reset mtvec_o", bus.mtvec_o, 32'h0);
    check("reset mepc_o", bus.mepc_o, 32'h0);
    check("reset mie_o", {31'd0, bus.mie_o}, 32'h0);
    csr(12'hB00, 2'd0, 0); check("mcycle t0", bus.csr_rdata_o, 32'd0);
    csr(12'hB00, 2'd0, 0); check("mcycle t1", bus.csr_rdata_o, 32'd1);
    csr(12'hB00, 2'd0, 0); check("mcycle t2", bus.csr_rdata_o, 32'd2);
    csr(12'h301, 2'd0, 0); check("misa", bus.csr_rdata_o, 32'h40000100);
    check("misa illegal", {31'd0, bus.csr_illegal_o}, 32'd0);
    csr(12'hF14, 2'd0, 0); check("mhartid", bus.csr_rdata_o, 32'h0);

    // mtvec alignment and mscratch set/clear.
    csr(12'h305, 2'd1, 32'h80000003);
    csr(12'h305, 2'd0, 0); check("mtvec read", bus.csr_rdata_o, 32'h80000000);
    check("mtvec_o", bus.mtvec_o, 32'h80000000);
    csr(12'h340, 2'd2, 32'h0F);
    csr(12'h340, 2'd3, 32'h05);
    csr(12'h340, 2'd0, 0); check("mscratch RS/RC", bus.csr_rdata_o, 32'h0A);

    // Illegal accesses.
    csr(12'hF14, 2'd1, 32'h1); check("RW mhartid illegal", {31'd0, bus.csr_illegal_o}, 32'd1);
    csr(12'h7C0, 2'd1, 32'h5); check("unimpl illegal", {31'd0, bus.csr_illegal_o}, 32'd1);
    check("unimpl reads 0", bus.csr_rdata_o, 32'h0);
    csr(12'h7C0, 2'd0, 0); check("op none legal", {31'd0, bus.csr_illegal_o}, 32'd0);
    csr(12'hF14, 2'd2, 0); check("RS ro zero legal", {31'd0, bus.csr_illegal_o}, 32'd0);

    // Counter carry and 64-bit wrap.
    csr(12'hB00, 2'd1, 32'hFFFFFFFF);
    csr(12'hB00, 2'd0, 0); check("mcycle low written", bus.csr_rdata_o, 32'hFFFFFFFF);
    csr(12'hB80, 2'd0, 0); check("mcycleh carry", bus.csr_rdata_o, 32'h1);
    csr(12'hB80, 2'd1, 32'hFFFFFFFF);
    csr(12'hB00, 2'd1, 32'hFFFFFFFE);
    csr(12'hB80, 2'd0, 0); check("mcycleh before wrap", bus.csr_rdata_o, 32'hFFFFFFFF);
    csr(12'hB00, 2'd0, 0); check("mcycle before wrap", bus.csr_rdata_o, 32'hFFFFFFFF);
    csr(12'hB80, 2'd0, 0); check("mcycleh wrapped", bus.csr_rdata_o, 32'h0);

    // Trap entry beats a simultaneous CSR write.
    csr(12'h300, 2'd2, 32'h8);
    csr(12'h300, 2'd0, 0); check("mstatus MIE set", bus.csr_rdata_o, 32'h1808);
    check("mie_o set", {31'd0, bus.mie_o}, 32'd1);
    s = '0; s.addr = 12'h340; s.op = 2'd1; s.wdata = 32'hDEADBEEF;
    s.trap = 1'b1; s.cause = 32'hB; s.pc = 32'h1006;
    step(s);
    csr(12'h341, 2'd0, 0); check("trap mepc", bus.csr_rdata_o, 32'h1004);
    check("trap mepc_o", bus.mepc_o, 32'h1004);
    csr(12'h342, 2'd0, 0); check("trap mcause", bus.csr_rdata_o, 32'hB);
    csr(12'h300, 2'd0, 0); check("trap mstatus", bus.csr_rdata_o, 32'h1880);
    csr(12'h340, 2'd0, 0); check("trap drops write", bus.csr_rdata_o, 32'h0A);

    // mret, then trap and mret together.
    s = '0; s.mret = 1'b1; s.addr = 12'h340; s.op = 2'd1; s.wdata = 32'h55;
    step(s);
    csr(12'h300, 2'd0, 0); check("mret mstatus", bus.csr_rdata_o, 32'h1888);
    check("mret mie_o", {31'd0, bus.mie_o}, 32'd1);
    s = '0; s.trap = 1'b1; s.mret = 1'b1; s.cause = 32'h2; s.pc = 32'h2000;
    step(s);
    csr(12'h300, 2'd0, 0); check("trap over mret", bus.csr_rdata_o, 32'h1880);
    check("trap over mret mepc", bus.mepc_o, 32'h2000);

    // minstret counting and reset mid-run.
    for (int i = 0; i < 5; i++) begin
      s = '0; s.addr = 12'hB02; s.instret = 1'b1;
      step(s);
    end
    csr(12'hB02, 2'd0, 0); check("minstret 5", bus.csr_rdata_o, 32'd5);
    s = '0; s.rst = 1'b1; s.trap = 1'b1; s.cause = 32'h7; s.pc = 32'h40;
    s.addr = 12'h340; s.op = 2'd1; s.wdata = 32'h1234; s.instret = 1'b1;
    step(s);
    s = '0; s.rst = 1'b1; s.addr = 12'hB00;
    step(s); check("mcycle in reset", bus.csr_rdata_o, 32'd0);
    csr(12'hB02, 2'd0, 0); check("minstret after rst", bus.csr_rdata_o, 32'd0);
    check("mtvec_o after rst", bus.mtvec_o, 32'h0);
    csr(12'h340, 2'd0, 0); check("mscratch after rst", bus.csr_rdata_o, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      s = '0;
      s.addr = ADDRS[$urandom_range(0, 14)];
      s.op   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       s.wdata = 32'h0;
        1:       s.wdata = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: s.wdata = $urandom;
      endcase
      s.instret = 1'($urandom_range(0, 1));
      s.trap    = ($urandom_range(0, 15) == 0);
      s.mret    = ($urandom_range(0, 15) == 0);
      s.cause   = $urandom;
      s.pc      = $urandom;
      s.rst     = ($urandom_range(0, 299) == 0);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
